fetch_seq: RTL

Multi-cycle instruction fetch controller for the Y86-64 SEQ core. Reads an instruction one byte at a time from a byte-wide instruction memory port with a req/ack handshake and works out the instruction length from the first byte. Assembles icode/ifun/rA/rB/valC, computes valP, and presents the decoded fields to the decode stage through a valid/ready handshake. It sequences instruction memory and sits between the PC-select logic and decode.

---
 rtl/y86_fetch_pkg.sv | 63 ++++++
 rtl/instr_len_decode.sv | 56 +++++
 rtl/fetch_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/y86_fetch_pkg.sv
// ---------------------------------------------------------------------------
// y86_fetch_pkg
// Shared definitions for the Y86-64 multi-cycle fetch controller:
//   - icode constants (I_HALT .. I_POPQ)
//   - register-none encoding REG_NONE
//   - fetch FSM state enum (adds ST_HALTED when FETCH_HALT_STOP_EN is defined)
//   - valc_insert(): places one little-endian byte into the constant word
// Configuration macro: FETCH_HALT_STOP_EN
// ---------------------------------------------------------------------------
package y86_fetch_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

`ifdef FETCH_HALT_STOP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DONE   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DONE   = 2'd2
    } fetch_state_e;
`endif

    // Write byte b into lane idx (0 = least significant) of cur; out-of-range
    // lanes leave the word untouched.
    function automatic logic [63:0] valc_insert(input logic [63:0] cur,
                                                input logic [3:0]  idx,
                                                input logic [7:0]  b);
        logic [63:0] r;
        r = cur;
        case (idx)
            4'd0:    r[7:0]   = b;
            4'd1:    r[15:8]  = b;
            4'd2:    r[23:16] = b;
            4'd3:    r[31:24] = b;
            4'd4:    r[39:32] = b;
            4'd5:    r[47:40] = b;
            4'd6:    r[55:48] = b;
            4'd7:    r[63:56] = b;
            default: r = cur;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// ---------------------------------------------------------------------------
// instr_len_decode
// Combinational length/format decoder for a Y86-64 icode.
// Ports:
//   icode        in  4  instruction code (upper nibble of byte 0)
//   length       out 4  instruction length in bytes (1, 2, 9 or 10)
//   has_regs     out 1  byte 1 is a register specifier byte
//   has_valc     out 1  instruction carries an 8-byte constant
//   valc_offset  out 4  byte index where the constant starts
//   valid        out 1  icode is a defined instruction
// ---------------------------------------------------------------------------
module instr_len_decode
    import y86_fetch_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] length,
    output logic       has_regs,
    output logic       has_valc,
    output logic [3:0] valc_offset,
    output logic       valid
);

    // Format lookup; undefined icodes are treated as 1-byte invalid instructions.
    always_comb begin
        length      = 4'd1;
        has_regs    = 1'b0;
        has_valc    = 1'b0;
        valc_offset = 4'd0;
        valid       = 1'b1;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                length = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                length   = 4'd2;
                has_regs = 1'b1;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                length      = 4'd10;
                has_regs    = 1'b1;
                has_valc    = 1'b1;
                valc_offset = 4'd2;
            end
            I_JXX, I_CALL: begin
                length      = 4'd9;
                has_valc    = 1'b1;
                valc_offset = 4'd1;
            end
            default: begin
                length = 4'd1;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// ---------------------------------------------------------------------------
// fetch_seq
// Multi-cycle Y86-64 instruction fetch: reads one byte per mem_ack from a
// byte-wide memory port, assembles icode/ifun/rA/rB/valC, computes valP and
// hands the result to decode over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start, pc           begin a fetch at pc (IDLE, or DONE with out_ready)
//   mem_req, mem_addr   byte read request and address (pc_reg + byte_cnt)
//   mem_rdata, mem_ack, mem_err   read byte, completion, address fault
//   out_valid, out_ready          decode handshake
//   icode, ifun, rA, rB, valc, valp, instr_valid, error   fetched fields
//   busy                state != IDLE
// Configuration macro: FETCH_HALT_STOP_EN -- when defined, handing off a
// halt, invalid or faulted instruction parks the block in a terminal HALTED
// state that only rst_n leaves.
// ---------------------------------------------------------------------------
module fetch_seq
    import y86_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic        instr_valid,
    output logic        error,
    output logic        busy
);

    fetch_state_e state_r;
    fetch_state_e state_next_s;

    logic [63:0] pc_r;
    logic [3:0]  byte_cnt_r;
    logic [3:0]  icode_r;
    logic [3:0]  ifun_r;
    logic [3:0]  ra_r;
    logic [3:0]  rb_r;
    logic [63:0] valc_r;
    logic [63:0] valp_r;
    logic        instr_valid_r;
    logic        error_r;

    logic [3:0]  dec_icode_s;
    logic [3:0]  dec_len_s;
    logic        dec_has_regs_s;
    logic        dec_has_valc_s;
    logic [3:0]  dec_valc_off_s;
    logic        dec_valid_s;

    logic        accept_s;
    logic        last_s;
    logic        load_s;
`ifdef FETCH_HALT_STOP_EN
    logic        halt_cond_s;
`endif

    assign mem_addr    = pc_r + {60'd0, byte_cnt_r};
    assign icode       = icode_r;
    assign ifun        = ifun_r;
    assign rA          = ra_r;
    assign rB          = rb_r;
    assign valc        = valc_r;
    assign valp        = valp_r;
    assign instr_valid = instr_valid_r;
    assign error       = error_r;

    // Byte 0 is still on the bus when its own length is needed, so decode it
    // directly; later bytes use the captured icode.
    always_comb begin
        dec_icode_s = icode_r;
        if (byte_cnt_r == 4'd0) begin
            dec_icode_s = mem_rdata[7:4];
        end else begin
            dec_icode_s = icode_r;
        end
    end

    instr_len_decode u_len_dec (
        .icode       (dec_icode_s),
        .length      (dec_len_s),
        .has_regs    (dec_has_regs_s),
        .has_valc    (dec_has_valc_s),
        .valc_offset (dec_valc_off_s),
        .valid       (dec_valid_s)
    );

    assign accept_s = (state_r == ST_FETCH) && mem_ack;
    assign last_s   = ((byte_cnt_r + 4'd1) == dec_len_s);

`ifdef FETCH_HALT_STOP_EN
    assign halt_cond_s = (icode_r == I_HALT) || !instr_valid_r || error_r;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus state-decoded handshake outputs (mem_req,
    // out_valid, busy depend on state_r only, never on mem_ack).
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        mem_req      = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack && (mem_err || last_s)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef FETCH_HALT_STOP_EN
                    if (halt_cond_s) begin
                        state_next_s = ST_HALTED;
                    end else if (start) begin
                        load_s       = 1'b1;
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
`else
                    if (start) begin
                        load_s       = 1'b1;
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
`endif
                end else begin
                    state_next_s = ST_DONE;
                end
            end
`ifdef FETCH_HALT_STOP_EN
            ST_HALTED: begin
                state_next_s = ST_HALTED;
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Fetch datapath: load a new pc, then capture each accepted byte into its field.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= 64'd0;
            byte_cnt_r    <= 4'd0;
            icode_r       <= 4'd0;
            ifun_r        <= 4'd0;
            ra_r          <= REG_NONE;
            rb_r          <= REG_NONE;
            valc_r        <= 64'd0;
            valp_r        <= 64'd0;
            instr_valid_r <= 1'b1;
            error_r       <= 1'b0;
        end else if (load_s) begin
            pc_r          <= pc;
            byte_cnt_r    <= 4'd0;
            icode_r       <= 4'd0;
            ifun_r        <= 4'd0;
            ra_r          <= REG_NONE;
            rb_r          <= REG_NONE;
            valc_r        <= 64'd0;
            valp_r        <= 64'd0;
            instr_valid_r <= 1'b1;
            error_r       <= 1'b0;
        end else if (accept_s) begin
            if (mem_err) begin
                // The faulting byte's address becomes valp; captured fields stay.
                error_r <= 1'b1;
                valp_r  <= mem_addr;
            end else begin
                if (byte_cnt_r == 4'd0) begin
                    icode_r       <= mem_rdata[7:4];
                    ifun_r        <= mem_rdata[3:0];
                    instr_valid_r <= dec_valid_s;
                    valp_r        <= pc_r + {60'd0, dec_len_s};
                end else if (dec_has_regs_s && (byte_cnt_r == 4'd1)) begin
                    ra_r <= mem_rdata[7:4];
                    rb_r <= mem_rdata[3:0];
                end else if (dec_has_valc_s) begin
                    valc_r <= valc_insert(valc_r, byte_cnt_r - dec_valc_off_s, mem_rdata);
                end else begin
                    valc_r <= valc_r;
                end
                if (!last_s) begin
                    byte_cnt_r <= byte_cnt_r + 4'd1;
                end else begin
                    byte_cnt_r <= byte_cnt_r;
                end
            end
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

endmodule
